// File: rtl/line_request_splitter_pkg.sv
// Shared memory-request definitions for the line request splitter.
//   LINE_BYTES / LOG_LINE : default line geometry
//   ADDR_W / TAG_W        : default address and tag widths
//   state_e               : splitter control states
//   txn_t                 : one line-sized transaction as seen downstream
package mem_pkg;

  localparam int LINE_BYTES = 128;
  localparam int LOG_LINE   = $clog2(LINE_BYTES);
  localparam int ADDR_W     = 64;
  localparam int TAG_W      = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [LOG_LINE-1:0] offset;
    logic [LOG_LINE:0]   bytes;
    logic                first;
    logic                last;
    logic [TAG_W-1:0]    tag;
  } txn_t;

endpackage

// File: rtl/line_request_splitter_alignment_unit.sv
// Combinational alignment of a byte access onto line boundaries.
//   addr      : byte address of the access
//   size      : access size in bytes
//   line_base : addr with the in-line offset bits cleared
//   offset    : byte offset of addr inside its line
//   units     : number of lines touched, ceil((offset + size) / LINE_BYTES)
module alignment_unit #(
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_BYTES = 128
) (
  input  logic [ADDR_WIDTH-1:0]              addr,
  input  logic [31:0]                        size,
  output logic [ADDR_WIDTH-1:0]              line_base,
  output logic [$clog2(LINE_BYTES)-1:0]      offset,
  output logic [33-$clog2(LINE_BYTES):0]     units
);
  import mem_pkg::*;

  localparam int OFF_W = $clog2(LINE_BYTES);

  // 34 bits holds offset + size + (LINE_BYTES-1) for any 32-bit size.
  logic [33:0] span;

  assign offset    = addr[OFF_W-1:0];
  assign line_base = {addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign span      = {2'b00, size} + {{(34-OFF_W){1'b0}}, offset} + 34'(LINE_BYTES - 1);
  assign units     = span[33:OFF_W];

endmodule

// File: rtl/line_request_splitter.sv
// Splits one byte-granular access into line-sized transactions, lowest
// address first, one transaction per cycle while downstream is ready.
//   clk, rst    : clock, asynchronous active-high reset
//   req_*       : request side (valid/ready), addr/size/tag of the access
//   txn_*       : transaction side (valid/ready), line base, in-line offset,
//                 byte count, first/last markers and the request tag
//   busy        : high while a request is being split (ISSUE state)
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; a valid, once raised, holds its payload stable until the
// transfer. req_ready is a pure state decode and never depends on txn_ready.
module line_request_splitter #(
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_BYTES = mem_pkg::LINE_BYTES,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [31:0]                   req_size,
  input  logic [TAG_WIDTH-1:0]          req_tag,
  output logic                          txn_valid,
  input  logic                          txn_ready,
  output logic [ADDR_WIDTH-1:0]         txn_addr,
  output logic [$clog2(LINE_BYTES)-1:0] txn_offset,
  output logic [$clog2(LINE_BYTES):0]   txn_bytes,
  output logic                          txn_first,
  output logic                          txn_last,
  output logic [TAG_WIDTH-1:0]          txn_tag,
  output logic                          busy
);
  import mem_pkg::*;

  localparam int OFF_W   = $clog2(LINE_BYTES);
  localparam int UNITS_W = 34 - OFF_W;
  localparam logic [OFF_W:0]          LINE_FULL = (OFF_W+1)'(LINE_BYTES);
  localparam logic [ADDR_WIDTH-1:0]   LINE_STEP = ADDR_WIDTH'(LINE_BYTES);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [OFF_W-1:0]       offset_q, offset_d;
  logic [31:0]            remaining_q, remaining_d;
  logic                   first_q, first_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [UNITS_W-1:0]     units_q, units_d;
  logic [UNITS_W-1:0]     count_q, count_d;

  logic [ADDR_WIDTH-1:0]  al_base;
  logic [OFF_W-1:0]       al_offset;
  logic [UNITS_W-1:0]     al_units;

  logic                   issuing;
  logic [OFF_W:0]         avail;
  logic                   fits;
  logic [OFF_W:0]         step_bytes;

  alignment_unit #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LINE_BYTES (LINE_BYTES)
  ) u_align (
    .addr      (req_addr),
    .size      (req_size),
    .line_base (al_base),
    .offset    (al_offset),
    .units     (al_units)
  );

  // Bytes left in the current line; remaining is compared against it directly
  // so offset + size is never formed in 32 bits.
  assign issuing    = (state_q == ISSUE);
  assign avail      = LINE_FULL - {1'b0, offset_q};
  assign fits       = (remaining_q <= 32'(avail));
  assign step_bytes = fits ? remaining_q[OFF_W:0] : avail;

  assign req_ready  = (state_q == IDLE);
  assign busy       = issuing;
  assign txn_valid  = issuing;
  assign txn_addr   = addr_q;
  assign txn_offset = offset_q;
  assign txn_tag    = tag_q;
  // Gated by state so the markers and count read zero while idle.
  assign txn_bytes  = issuing ? step_bytes : '0;
  assign txn_first  = issuing & first_q;
  assign txn_last   = issuing & fits;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    offset_d    = offset_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    tag_d       = tag_q;
    units_d     = units_q;
    count_d     = count_q;
    case (state_q)
      IDLE: begin
        // A zero-size request is consumed without leaving IDLE.
        if (req_valid && req_size != 32'd0) begin
          state_d     = ISSUE;
          addr_d      = al_base;
          offset_d    = al_offset;
          remaining_d = req_size;
          first_d     = 1'b1;
          tag_d       = req_tag;
          units_d     = al_units;
          count_d     = '0;
        end
      end
      ISSUE: begin
        if (txn_ready) begin
          count_d = count_q + UNITS_W'(1);
          if (fits) begin
            state_d = IDLE;
          end else begin
            addr_d      = addr_q + LINE_STEP;
            remaining_d = remaining_q - 32'(step_bytes);
            offset_d    = '0;
            first_d     = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      offset_q    <= '0;
      remaining_q <= '0;
      first_q     <= 1'b0;
      tag_q       <= '0;
      units_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      offset_q    <= offset_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      tag_q       <= tag_d;
      units_q     <= units_d;
      count_q     <= count_d;
    end
  end

`ifndef SYNTHESIS
  // The final transaction of a request must close exactly the number of
  // lines the alignment unit predicted at accept time.
  always_ff @(posedge clk) begin
    if (!rst && issuing && txn_ready && fits) begin
      assert (count_q + UNITS_W'(1) == units_q)
        else $error("line count %0d differs from predicted %0d", count_q + UNITS_W'(1), units_q);
    end
  end
`endif

endmodule

// File: doc/line_request_splitter.md
Name: line_request_splitter

Overview:
- Sits between the SM load/store request path and the L1/L2 transaction queue.
- Accepts one byte-granular access (addr, size, tag) and emits one line-sized memory transaction per LINE_BYTES line touched, in ascending address order.
- Each transaction carries the line base, the byte offset inside the line, the byte count and first/last markers.
- Uses valid/ready on both sides and handles one request at a time.

Parameters:
- ADDR_WIDTH, 64, byte-address width.
- LINE_BYTES, 128, line size in bytes; must be a power of two and at least 4.
- TAG_WIDTH, 8, width of the opaque request tag carried to every transaction.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  32  size in bytes; 0 is legal.
- req_tag  in  TAG_WIDTH  request identifier.
- txn_valid  out  1  transaction present.
- txn_ready  in  1  downstream accepts the transaction.
- txn_addr  out  ADDR_WIDTH  line-aligned base address.
- txn_offset  out  log2(LINE_BYTES)  first valid byte within the line.
- txn_bytes  out  log2(LINE_BYTES)+1  valid byte count, range 1..LINE_BYTES.
- txn_first  out  1  first transaction of the request.
- txn_last  out  1  final transaction of the request.
- txn_tag  out  TAG_WIDTH  copy of req_tag.
- busy  out  1  a request is being split.

Behaviour:
- Reset values: txn_valid=0, busy=0, req_ready=1, every data output=0. State machine goes to IDLE.
- State machine states: IDLE and ISSUE.
- req_ready = (state==IDLE). It is a pure state decode with no combinational path from txn_ready.
- IDLE accept (req_valid & req_ready), size>0:
  - latch line base (addr with low log2(LINE_BYTES) bits cleared), offset and remaining=size;
  - go to ISSUE; txn_valid rises the next cycle (latency 1);
  - set txn_first=1.
- IDLE accept with size==0: request is consumed, no transaction is emitted, state stays IDLE, req_ready stays 1.
- ISSUE output computation:
  - txn_bytes = min(remaining, LINE_BYTES - offset);
  - txn_last = (remaining <= LINE_BYTES - offset);
  - all txn_* outputs come from registers or this min/compare logic only.
- Backpressure: while txn_valid=1 and txn_ready=0, every txn_* output holds stable.
- ISSUE handshake, non-last: txn_addr += LINE_BYTES (modulo 2^ADDR_WIDTH, wraps to 0), remaining -= txn_bytes, offset=0, txn_first=0. The next line is presented the following cycle, giving one line per cycle under continuous ready.
- ISSUE handshake, last: go to IDLE, txn_valid=0 and req_ready=1 the next cycle. This is one bubble cycle per request.
- Transaction count per request = ceil((offset+size)/LINE_BYTES).
- remaining register is 32 bits. Size up to 2^32-1 is supported with no overflow, because the sum offset+size is never formed as a 32-bit value.
- busy = (state==ISSUE).
- rst asserted mid-burst: the request is abandoned and all outputs return to reset values immediately. No partial-transaction completion is required.

Decomposition:
- Shared package mem_pkg:
  - LINE_BYTES, LOG_LINE;
  - a txn struct/typedef {addr, offset, bytes, first, last, tag};
  - a state enum {IDLE, ISSUE}.
- One natural sub-module: the existing combinational alignment_unit, instantiated on the request inputs to produce the line base and offset at accept time. Its units output feeds an optional assertion cross-checking the transaction count.

Test Plan (LINE_BYTES=128):
- addr 0x1000, size 128 -> exactly one transaction: 0x1000, offset 0, bytes 128, first=1, last=1; req_ready back to 1 two cycles after accept.
- addr 0x107C, size 8, ready held high -> two consecutive cycles:
  - (0x1000, offset 0x7C, bytes 4, first);
  - (0x1080, offset 0, bytes 4, last).
- addr 0x1010, size 300 -> three transactions, last on the third; byte sum 300:
  - (0x1000, 16, 112);
  - (0x1080, 0, 128);
  - (0x1100, 0, 60).
- Same 300-byte request with txn_ready low for 3 cycles on the second transaction -> outputs (0x1080, 0, 128, first=0, last=0) stable for all 4 cycles; no transaction lost or duplicated.
- Size 0 then addr 0xFFFF_FFFF_FFFF_FFF0, size 32 -> first request emits nothing and req_ready stays 1. Second request emits:
  - (0xFFFF_FFFF_FFFF_FF80, 0x70, 16);
  - (0x0, 0, 16, last).
- rst pulsed while the second of three transactions is pending -> txn_valid=0, busy=0, req_ready=1 immediately. A new request afterwards splits correctly with first=1.
